// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU M-stage strobe/stall handshake.
// Captures one load or store, holds the pipeline for LATENCY cycles, then acks once.
module dmem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_stb_in,
    input  logic        data_we_in,
    input  logic [31:0] data_addr_in,
    input  logic [31:0] data_wdata_in,
    input  logic [3:0]  data_sel_in,
    output logic        data_stall_out,
    output logic        data_ack_out,
    output logic        data_err_out,
    output logic [31:0] data_rdata_out
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
    localparam logic        ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_sel;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH];

    logic          w_cap;
    logic          w_enter_resp;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_sel;
    logic [32:0]   w_off;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic          w_wr;

    assign w_cap        = (r_state == IDLE) && data_stb_in;
    assign w_enter_resp = ((r_state == WAIT) && (r_cnt == 4'd0)) || (w_cap && ZERO_LAT);

    // With zero latency the request is served in its capture cycle, so bypass the request register
    assign w_we    = w_cap ? data_we_in    : r_we;
    assign w_addr  = w_cap ? data_addr_in  : r_addr;
    assign w_wdata = w_cap ? data_wdata_in : r_wdata;
    assign w_sel   = w_cap ? data_sel_in   : r_sel;

    // Offset below BASE_ADDR wraps into bit 32 and so fails the span compare
    assign w_off = {1'b0, w_addr} - {1'b0, BASE_ADDR};
    assign w_err = (w_addr[1:0] != 2'b00) || (w_off >= SPAN);
    assign w_idx = w_off[AW+1:2];
    assign w_wr  = w_enter_resp && !w_err && w_we && rst_n;

    assign data_stall_out = w_cap || (r_state == WAIT);
    assign data_ack_out   = r_ack;
    assign data_err_out   = r_err;
    assign data_rdata_out = r_rdata;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_sel[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_sel   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
            case (r_state)
                IDLE: begin
                    if (data_stb_in) begin
                        r_we    <= data_we_in;
                        r_addr  <= data_addr_in;
                        r_wdata <= data_wdata_in;
                        r_sel   <= data_sel_in;
                        r_cnt   <= CNT_INIT;
                        r_state <= ZERO_LAT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_enter_resp) begin
                r_ack   <= 1'b1;
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 0) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [1:0]  stall;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] rdata [2];

    int total = 0;
    int bad   = 0;

    localparam int          LAT   [2] = '{2, 0};
    localparam longint      BASEA [2] = '{64'h0, 64'h1000};
    localparam longint      DEP   [2] = '{64, 16};

    dmem_responder #(.DEPTH(64), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .data_stb_in(stb[0]), .data_we_in(we),
        .data_addr_in(addr), .data_wdata_in(wdata), .data_sel_in(sel),
        .data_stall_out(stall[0]), .data_ack_out(ack[0]), .data_err_out(err[0]),
        .data_rdata_out(rdata[0])
    );

    dmem_responder #(.DEPTH(16), .LATENCY(0), .BASE_ADDR(32'h0000_1000)) u_dut_l0 (
        .clk(clk), .rst_n(rst_n), .data_stb_in(stb[1]), .data_we_in(we),
        .data_addr_in(addr), .data_wdata_in(wdata), .data_sel_in(sel),
        .data_stall_out(stall[1]), .data_ack_out(ack[1]), .data_err_out(err[1]),
        .data_rdata_out(rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding request per responder, ack due at capture+1+LAT
    int          cyc = 0;
    bit          pend  [2];
    int          t_ack [2];
    bit          q_we  [2];
    logic [31:0] q_addr[2];
    logic [31:0] q_wd  [2];
    logic [3:0]  q_sel [2];
    logic [31:0] m_mem [int];

    function automatic bit is_err(input int d, input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (a[1:0] != 2'b00) || (la < BASEA[d]) || (la >= BASEA[d] + 4 * DEP[d]);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pend[d] = 1'b0;
            end else if (pend[d] && cyc == t_ack[d]) begin
                pend[d] = 1'b0;
            end else if (!pend[d] && stb[d]) begin
                pend[d]   = 1'b1;
                t_ack[d]  = cyc + 1 + LAT[d];
                q_we[d]   = we;
                q_addr[d] = addr;
                q_wd[d]   = wdata;
                q_sel[d]  = sel;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit          p, e_ack, e_err, e_stall, known;
            logic [31:0] e_rd, w;
            int          key;
            p = pend[d] && rst_n;
            e_ack = 1'b0; e_err = 1'b0; e_rd = 32'd0; known = 1'b1;
            e_stall = p ? (cyc < t_ack[d]) : stb[d];
            if (p && cyc == t_ack[d]) begin
                e_ack = 1'b1;
                e_err = is_err(d, q_addr[d]);
                if (!e_err) begin
                    key = d * 65536 + int'((longint'(q_addr[d]) - BASEA[d]) >> 2);
                    if (q_we[d]) begin
                        if (m_mem.exists(key)) begin
                            w = m_mem[key];
                            for (int b = 0; b < 4; b++)
                                if (q_sel[d][b]) w[8*b +: 8] = q_wd[d][8*b +: 8];
                            m_mem[key] = w;
                        end else if (q_sel[d] == 4'hF) begin
                            m_mem[key] = q_wd[d];
                        end
                    end else if (m_mem.exists(key)) begin
                        e_rd = m_mem[key];
                    end else begin
                        known = 1'b0;
                    end
                end
            end
            chk($sformatf("stall%0d", d), 32'(stall[d]), 32'(e_stall));
            chk($sformatf("ack%0d", d),   32'(ack[d]),   32'(e_ack));
            chk($sformatf("err%0d", d),   32'(err[d]),   32'(e_err));
            if (known) chk($sformatf("rdata%0d", d), rdata[d], e_rd);
        end
    end

    // Wait for ack on responder d; lat counts cycles from request start to ack
    task automatic wait_ack(input int d, input int n0, input bit keep,
                            output logic [31:0] rd, output bit e, output int lat);
        bit got;
        int n;
        got = 1'b0; n = n0; rd = 32'hx; e = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (ack[d]) begin
                got = 1'b1; rd = rdata[d]; e = err[d];
            end else begin
                n++;
            end
            @(posedge clk); #1;
        end
        lat = n;
        if (!got) chk($sformatf("timeout%0d", d), 32'd0, 32'd1);
        if (!keep) stb[d] = 1'b0;
    endtask

    task automatic req(input int d, input bit w_e, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input bit keep,
                       output logic [31:0] rd, output bit e, output int lat);
        stb[d] = 1'b1; we = w_e; addr = a; wdata = wd; sel = s;
        wait_ack(d, 0, keep, rd, e, lat);
    endtask

    logic [31:0] rd;
    bit          e;
    int          lat;

    initial begin
        rst_n = 1'b0; stb = 2'b00; we = 1'b0; addr = 32'd0; wdata = 32'd0; sel = 4'd0;
        @(negedge clk);
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_rdata", rdata[0],   32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full-word store then load, LATENCY 2
        req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, e, lat);
        chk("st_lat", 32'(lat), 32'd3);
        chk("st_err", 32'(e),   32'd0);
        chk("st_rd",  rd,       32'd0);
        req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, e, lat);
        chk("ld_rd", rd, 32'hDEAD_BEEF);

        // Byte-masked store
        req(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, rd, e, lat);
        req(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, e, lat);
        req(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("mask_rd", rd, 32'h11BB_33DD);

        // Errors: misaligned, just past the top, and an out-of-range store
        req(0, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0, rd, e, lat);
        req(0, 1'b0, 32'h13, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("mis_err", 32'(e), 32'd1);
        chk("mis_rd",  rd,     32'd0);
        req(0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("oor_err", 32'(e), 32'd1);
        chk("oor_rd",  rd,     32'd0);
        req(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, e, lat);
        chk("oor_st_err", 32'(e), 32'd1);
        req(0, 1'b1, 32'h11, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, e, lat);
        req(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("oor_keep0", rd, 32'h0);
        req(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("mis_keep10", rd, 32'hDEAD_BEEF);

        // sel = 0 store writes nothing
        req(0, 1'b1, 32'h10, 32'h1234_5678, 4'h0, 1'b0, rd, e, lat);
        req(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("sel0_rd", rd, 32'hDEAD_BEEF);

        // Strobe dropped during WAIT: ack still on schedule, store performed
        stb[0] = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hCAFE_F00D; sel = 4'hF;
        @(posedge clk); #1;
        stb[0] = 1'b0;
        wait_ack(0, 1, 1'b0, rd, e, lat);
        chk("drop_lat", 32'(lat), 32'd3);
        req(0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("drop_rd", rd, 32'hCAFE_F00D);

        // Reset mid-WAIT abandons the store
        req(0, 1'b1, 32'h30, 32'h0, 4'hF, 1'b0, rd, e, lat);
        stb[0] = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h5555_5555; sel = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        chk("rstw_ack",   32'(ack[0]),   32'd0);
        chk("rstw_stall", 32'(stall[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req(0, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("rstw_rd", rd, 32'h0);

        // LATENCY 0 with strobe held across back-to-back requests
        req(1, 1'b1, 32'h1000, 32'h0102_0304, 4'hF, 1'b0, rd, e, lat);
        chk("l0_lat", 32'(lat), 32'd1);
        req(1, 1'b1, 32'h103C, 32'hA5A5_A5A5, 4'hF, 1'b1, rd, e, lat);
        req(1, 1'b0, 32'h103C, 32'h0, 4'hF, 1'b1, rd, e, lat);
        chk("l0_b2b_lat", 32'(lat), 32'd1);
        chk("l0_top_rd",  rd,       32'hA5A5_A5A5);
        req(1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("l0_base_rd", rd, 32'h0102_0304);
        req(1, 1'b0, 32'h0FFC, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("l0_below_err", 32'(e), 32'd1);
        req(1, 1'b0, 32'h1040, 32'h0, 4'hF, 1'b0, rd, e, lat);
        chk("l0_above_err", 32'(e), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the CPU M-stage strobe interface.
- Accepts single load and store requests on the CPU's data strobe.
- Holds the pipeline with data_stall_out while a request is in flight, then returns a one-cycle ack with read data or an error flag.
- data_stall_out drives the hazard unit's data_stall_in. It is the responder end of the strobe/stall handshake the core initiates.

Parameters:
DEPTH, 1024, number of 32-bit words in the internal array; power of two, minimum 4
LATENCY, 2, wait-state cycles between request capture and response; 0 to 15
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4

Ports:
clk  in  1  core clock; everything is sampled on the rising edge
rst_n  in  1  asynchronous active-low reset
data_stb_in  in  1  CPU request strobe; held with all request fields until ack
data_we_in  in  1  1 = store, 0 = load
data_addr_in  in  32  byte address
data_wdata_in  in  32  store data
data_sel_in  in  4  byte enables; bit i selects bits 8i+7:8i
data_stall_out  out  1  pipeline hold request to the hazard unit
data_ack_out  out  1  one-cycle response strobe
data_err_out  out  1  qualifies ack: request rejected
data_rdata_out  out  32  load data, valid only while ack is high

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; counter = 0.
  - ack, err and rdata = 0.
  - Array contents are not initialised.
  - Reset during WAIT abandons the request; a pending store is not performed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On data_stb_in = 1, capture we, addr, wdata and sel into a request register.
  - Then go to WAIT with counter = LATENCY-1, or straight to RESP if LATENCY = 0.
- WAIT:
  - Decrement the counter each cycle.
  - When counter = 0, go to RESP.
  - data_stb_in is ignored here; requests cannot be aborted.
- RESP:
  - ack = 1 for exactly one cycle, then return to IDLE.
  - data_stb_in is ignored during RESP because the CPU is still holding the finished request.
  - The next request is sampled in the following IDLE cycle, so back-to-back requests have one IDLE gap.
- data_stall_out (combinational) = (IDLE and data_stb_in) or WAIT. It is 0 in RESP so the pipeline advances on the ack cycle.
- Latency: a request first seen in IDLE at cycle T gets its ack at cycle T+1+LATENCY. Stall is high from T through T+LATENCY.
- Error conditions, evaluated on the captured request:
  - The address is not word aligned (addr[1:0] != 0), or
  - The address lies outside BASE_ADDR to BASE_ADDR+4*DEPTH-1 (unsigned compare).
- On error: ack = 1 and err = 1, rdata = 0, no array write.
- Store, no error: write the array in the RESP-entry cycle, byte-masked by sel; bytes with sel = 0 are unchanged. sel = 0 is legal and writes nothing. rdata = 0 on store ack.
- Load, no error: rdata = full word at index (addr-BASE_ADDR)>>2. sel is ignored for loads; the CPU extracts bytes.
- Read-after-write: a load in the next request returns the data from the earlier store; no bypass is needed because of the IDLE gap.
- ack, err and rdata are registered; err and rdata are 0 whenever ack = 0.
- Counter width is 4 bits; no wrap is possible within the LATENCY range.

Test Plan:
- LATENCY=2, store addr 0x10, wdata 0xDEADBEEF, sel 4'hF at cycle T. Required: stall high at T, T+1, T+2; ack at T+3 with err=0; stall low at T+3. Then load 0x10: rdata 0xDEADBEEF at its ack.
- Byte-masked store: word at 0x20 holds 0x11223344; store 0xAABBCCDD with sel 4'b0101. Required: a following load of 0x20 returns 0x11BB33DD.
- Errors: load 0x13 (misaligned), then load of BASE_ADDR+4*DEPTH. Required: each gets ack=1, err=1, rdata=0. A subsequent load proves the array is unchanged.
- LATENCY=0: a load at T gives stall high only at T and ack at T+1. With stb held continuously, the next request is captured at T+2 and acked at T+3.
- Reset: assert rst_n=0 mid-WAIT of a store to 0x30 whose old value is 0x0. Required: ack, err, rdata and stall drop immediately (stall re-asserts only if stb is still high). A load of 0x30 after reset returns 0x0.
- Ignored stb: drop data_stb_in during WAIT. Required: ack still issues at the scheduled cycle and the store is performed.
